// File: rtl/led_g_pattern_driver.sv
// Green-LED driver: PWM dimming plus blink/chase/breathe animations, with control words applied only at frame ends.
// Optional breathe mode is built when LED_G_BREATHE_EN is defined; otherwise mode 11 acts as static.
module led_g_pattern_driver #(
    parameter int unsigned PWM_DIV = 196
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ctrl,
    output logic [7:0]  led_g,
    output logic        frame_strobe,
    output logic        apply_strobe
);

    localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);

    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_CHASE = 2'b10;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [7:0]       pwm_cnt_reg;
    logic [15:0]      frame_cnt_reg;
    logic [21:0]      act_reg;
    logic             phase_reg;
    logic [7:0]       pattern_reg;
    logic [7:0]       led_g_reg;
    logic             frame_strobe_reg;
    logic             apply_strobe_reg;

    logic [7:0]  act_mask;
    logic [7:0]  act_dim;
    logic [3:0]  act_rate;
    logic [1:0]  act_mode;
    logic        tick;
    logic        frame_end;
    logic        apply;
    logic        step;
    logic [15:0] step_len;
    logic [7:0]  eff_dim;
    logic        on;
    logic [7:0]  src_pattern;
    logic [7:0]  led_next;
    logic        unused_ctrl_bits;

    assign act_mask  = act_reg[7:0];
    assign act_dim   = act_reg[15:8];
    assign act_rate  = act_reg[19:16];
    assign act_mode  = act_reg[21:20];
    assign unused_ctrl_bits = ^ctrl[31:22];

    assign tick      = (div_cnt_reg == DIV_MAX);
    assign frame_end = tick && (pwm_cnt_reg == 8'hFF);
    assign apply     = frame_end && (ctrl[21:0] != act_reg);
    assign step_len  = (16'd1 << act_rate) - 16'd1;
    // An apply on the same frame end swallows the step.
    assign step      = frame_end && !apply && (frame_cnt_reg == step_len);

`ifdef LED_G_BREATHE_EN
    logic [7:0] level_reg;
    logic       dir_up_reg;
    logic [7:0] level_dec;

    assign level_dec = level_reg - 8'd1;
    assign eff_dim   = (act_mode == 2'b11) ? level_reg : act_dim;
`else
    assign eff_dim   = act_dim;
`endif

    assign on = (pwm_cnt_reg >= eff_dim);

    always_comb begin
        src_pattern = act_mask;
        case (act_mode)
            MODE_BLINK: src_pattern = phase_reg ? act_mask : 8'h00;
            MODE_CHASE: src_pattern = pattern_reg;
            default:    src_pattern = act_mask;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_led_bit
            assign led_next[gi] = src_pattern[gi] & on;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg      <= '0;
            pwm_cnt_reg      <= 8'd0;
            frame_cnt_reg    <= 16'd0;
            act_reg          <= 22'h0000FF;
            phase_reg        <= 1'b1;
            pattern_reg      <= 8'hFF;
            led_g_reg        <= 8'h00;
            frame_strobe_reg <= 1'b0;
            apply_strobe_reg <= 1'b0;
`ifdef LED_G_BREATHE_EN
            level_reg        <= 8'd0;
            dir_up_reg       <= 1'b1;
`endif
        end else begin
            div_cnt_reg      <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            if (tick) begin
                pwm_cnt_reg  <= pwm_cnt_reg + 8'd1;
            end
            frame_strobe_reg <= frame_end;
            apply_strobe_reg <= apply;
            led_g_reg        <= led_next;

            if (apply) begin
                act_reg       <= ctrl[21:0];
                phase_reg     <= 1'b1;
                pattern_reg   <= ctrl[7:0];
                frame_cnt_reg <= 16'd0;
`ifdef LED_G_BREATHE_EN
                level_reg     <= ctrl[15:8];
                dir_up_reg    <= 1'b1;
`endif
            end else if (step) begin
                frame_cnt_reg <= 16'd0;
                phase_reg     <= ~phase_reg;
                pattern_reg   <= {pattern_reg[6:0], pattern_reg[7]};
`ifdef LED_G_BREATHE_EN
                // Triangle between dim and 255; a dim of 255 pins the level.
                if (dir_up_reg) begin
                    if (level_reg != 8'hFF) begin
                        level_reg <= level_reg + 8'd1;
                        if (level_reg == 8'hFE) begin
                            dir_up_reg <= 1'b0;
                        end
                    end
                end else if (level_reg != act_dim) begin
                    level_reg <= level_dec;
                    if (level_dec == act_dim) begin
                        dir_up_reg <= 1'b1;
                    end
                end
`endif
            end else if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign led_g        = led_g_reg;
    assign frame_strobe = frame_strobe_reg;
    assign apply_strobe = apply_strobe_reg;

endmodule
